// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-memory accesses for lw/lb/lbu/sw/sb, stalls upstream until ack, registers results to Wr_*.
// Optional feature: define MEM_TIMEOUT_EN to abandon an unacknowledged access after 16 WAIT cycles and raise sticky mem_err.
module mem_stage (
    input  logic        clk,
    input  logic        rst,

    input  logic        Mem_valid,
    input  logic [5:0]  Mem_op,
    input  logic [4:0]  Mem_Reg,
    input  logic        Mem_RegWr,
    input  logic        Mem_MemtoReg,
    input  logic        Mem_MemWr,
    input  logic [31:0] Mem_alure,
    input  logic [31:0] Mem_busB,
    input  logic [31:2] Mem_PC,

    output logic        dm_req,
    output logic        dm_we,
    output logic [31:2] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,

    output logic        Wr_valid,
    output logic [5:0]  Wr_op,
    output logic [4:0]  Wr_Reg,
    output logic        Wr_RegWr,
    output logic        Wr_MemtoReg,
    output logic [31:0] Wr_alure,
    output logic [31:0] Wr_dout,
    output logic [31:2] Wr_PC,

    output logic        mem_stall,
    output logic        mem_err
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;

    state_t      state, state_next;
    logic        is_lw, is_lbyte, is_sw, is_sb, is_store, is_mem;
    logic        timeout;
    logic        retire_alu, retire_mem;
    logic        wr_regwr_d;
    logic [31:0] wr_dout_d;
    logic [31:0] rdata_shifted;
    logic        unused_memwr;

    // Store-ness comes from the opcode; the decoder's MemWr bit is redundant here.
    assign unused_memwr = Mem_MemWr;

    assign is_lw    = (Mem_op == OP_LW);
    assign is_lbyte = (Mem_op == OP_LB) || (Mem_op == OP_LBU);
    assign is_sw    = (Mem_op == OP_SW);
    assign is_sb    = (Mem_op == OP_SB);
    assign is_store = is_sw || is_sb;
    assign is_mem   = is_lw || is_lbyte || is_store;

`ifdef MEM_TIMEOUT_EN
    logic [3:0] tmo_cnt;

    assign timeout = (state == WAIT) && !dm_ack && (tmo_cnt == 4'hF);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= 4'h0;
            mem_err <= 1'b0;
        end else begin
            if (state == IDLE)
                tmo_cnt <= 4'h0;
            else if (!dm_ack)
                tmo_cnt <= tmo_cnt + 4'h1;
            if (timeout)
                mem_err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (Mem_valid && is_mem) state_next = WAIT;
            WAIT: if (dm_ack || timeout)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Access attributes are decoded straight from the held Mem_* inputs, so they stay constant for the whole WAIT.
    always_comb begin
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_be    = 4'b0000;
        dm_wdata = 32'h0;
        if (state == WAIT) begin
            dm_req  = 1'b1;
            dm_we   = is_store;
            dm_addr = Mem_alure[31:2];
            if (is_sb) begin
                dm_be    = 4'b0001 << Mem_alure[1:0];
                dm_wdata = {4{Mem_busB[7:0]}};
            end else begin
                dm_be    = 4'b1111;
                dm_wdata = is_sw ? Mem_busB : 32'h0;
            end
        end
    end

    assign mem_stall = ((state == IDLE) && Mem_valid && is_mem) ||
                       ((state == WAIT) && !dm_ack && !timeout);

    assign rdata_shifted = dm_rdata >> {Mem_alure[1:0], 3'b000};
    assign retire_alu    = (state == IDLE) && Mem_valid && !is_mem;
    assign retire_mem    = (state == WAIT) && (dm_ack || timeout);

    always_comb begin
        wr_regwr_d = 1'b0;
        wr_dout_d  = 32'h0;
        if (retire_alu) begin
            wr_regwr_d = Mem_RegWr;
        end else if (retire_mem && dm_ack) begin
            wr_regwr_d = Mem_RegWr && !is_store;
            if (is_lw)
                wr_dout_d = dm_rdata;
            else if (is_lbyte)
                wr_dout_d = {24'h0, rdata_shifted[7:0]};
        end
    end

    // Non-retiring cycles emit bubbles; payload fields simply hold their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            Wr_valid    <= 1'b0;
            Wr_op       <= 6'h0;
            Wr_Reg      <= 5'h0;
            Wr_RegWr    <= 1'b0;
            Wr_MemtoReg <= 1'b0;
            Wr_alure    <= 32'h0;
            Wr_dout     <= 32'h0;
            Wr_PC       <= '0;
        end else begin
            Wr_valid <= retire_alu || retire_mem;
            Wr_RegWr <= wr_regwr_d;
            if (retire_alu || retire_mem) begin
                Wr_op       <= Mem_op;
                Wr_Reg      <= Mem_Reg;
                Wr_MemtoReg <= Mem_MemtoReg;
                Wr_alure    <= Mem_alure;
                Wr_dout     <= wr_dout_d;
                Wr_PC       <= Mem_PC;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; the timeout section depends on MEM_TIMEOUT_EN.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        Mem_valid;
    logic [5:0]  Mem_op;
    logic [4:0]  Mem_Reg;
    logic        Mem_RegWr;
    logic        Mem_MemtoReg;
    logic        Mem_MemWr;
    logic [31:0] Mem_alure;
    logic [31:0] Mem_busB;
    logic [31:2] Mem_PC;
    logic        dm_req, dm_we;
    logic [31:2] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        Wr_valid;
    logic [5:0]  Wr_op;
    logic [4:0]  Wr_Reg;
    logic        Wr_RegWr, Wr_MemtoReg;
    logic [31:0] Wr_alure, Wr_dout;
    logic [31:2] Wr_PC;
    logic        mem_stall, mem_err;

    int compared   = 0;
    int mismatched = 0;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .Mem_valid(Mem_valid), .Mem_op(Mem_op), .Mem_Reg(Mem_Reg), .Mem_RegWr(Mem_RegWr),
        .Mem_MemtoReg(Mem_MemtoReg), .Mem_MemWr(Mem_MemWr), .Mem_alure(Mem_alure),
        .Mem_busB(Mem_busB), .Mem_PC(Mem_PC),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .Wr_valid(Wr_valid), .Wr_op(Wr_op), .Wr_Reg(Wr_Reg), .Wr_RegWr(Wr_RegWr),
        .Wr_MemtoReg(Wr_MemtoReg), .Wr_alure(Wr_alure), .Wr_dout(Wr_dout), .Wr_PC(Wr_PC),
        .mem_stall(mem_stall), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [5:0] op, input logic [4:0] rd,
                                 input logic regwr, input logic memwr,
                                 input logic [31:0] alure, input logic [31:0] busb);
        Mem_valid    = valid;
        Mem_op       = op;
        Mem_Reg      = rd;
        Mem_RegWr    = regwr;
        Mem_MemtoReg = op[5];
        Mem_MemWr    = memwr;
        Mem_alure    = alure;
        Mem_busB     = busb;
        Mem_PC       = 30'h0000_1000 + {25'h0, rd};
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        int stalls;
        int waits;

        rst      = 1'b1;
        dm_ack   = 1'b0;
        dm_rdata = 32'h0;
        applyStimulus(1'b0, 6'h00, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        checkOutput("rst_wr_valid", {31'h0, Wr_valid}, 32'h0);
        checkOutput("rst_wr_regwr", {31'h0, Wr_RegWr}, 32'h0);
        checkOutput("rst_wr_dout", Wr_dout, 32'h0);
        checkOutput("rst_wr_alure", Wr_alure, 32'h0);
        checkOutput("rst_dm_req", {31'h0, dm_req}, 32'h0);
        checkOutput("rst_dm_we", {31'h0, dm_we}, 32'h0);
        checkOutput("rst_dm_be", {28'h0, dm_be}, 32'h0);
        checkOutput("rst_mem_err", {31'h0, mem_err}, 32'h0);
        rst = 1'b0;

        // ALU op: one-edge pass-through, never stalls
        applyStimulus(1'b1, 6'b000000, 5'd5, 1'b1, 1'b0, 32'h0000_1234, 32'h0);
        checkOutput("alu_stall", {31'h0, mem_stall}, 32'h0);
        tick();
        applyStimulus(1'b0, 6'b000000, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("alu_wr_valid", {31'h0, Wr_valid}, 32'h1);
        checkOutput("alu_wr_alure", Wr_alure, 32'h0000_1234);
        checkOutput("alu_wr_reg", {27'h0, Wr_Reg}, 32'd5);
        checkOutput("alu_wr_dout", Wr_dout, 32'h0);
        checkOutput("alu_wr_regwr", {31'h0, Wr_RegWr}, 32'h1);
        tick();
        checkOutput("alu_bubble", {31'h0, Wr_valid}, 32'h0);

        // lw with three wait states
        applyStimulus(1'b1, 6'b100011, 5'd7, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        stalls = 0;
        if (mem_stall) stalls++;
        tick();
        checkOutput("lw_dm_req", {31'h0, dm_req}, 32'h1);
        checkOutput("lw_dm_addr", {2'b00, dm_addr}, 32'h40);
        checkOutput("lw_dm_we", {31'h0, dm_we}, 32'h0);
        checkOutput("lw_dm_be", {28'h0, dm_be}, 32'hF);
        checkOutput("lw_pending_valid", {31'h0, Wr_valid}, 32'h0);
        checkOutput("lw_pending_regwr", {31'h0, Wr_RegWr}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (mem_stall) stalls++;
            tick();
        end
        checkOutput("lw_addr_held", {2'b00, dm_addr}, 32'h40);
        dm_ack   = 1'b1;
        dm_rdata = 32'hDEAD_BEEF;
        #1;
        if (mem_stall) stalls++;
        checkOutput("lw_stall_cycles", stalls, 32'd4);
        tick();
        dm_ack = 1'b0;
        applyStimulus(1'b0, 6'h00, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("lw_wr_valid", {31'h0, Wr_valid}, 32'h1);
        checkOutput("lw_wr_dout", Wr_dout, 32'hDEAD_BEEF);
        checkOutput("lw_wr_regwr", {31'h0, Wr_RegWr}, 32'h1);
        checkOutput("lw_wr_reg", {27'h0, Wr_Reg}, 32'd7);
        checkOutput("lw_req_drop", {31'h0, dm_req}, 32'h0);
        tick();
        checkOutput("lw_valid_once", {31'h0, Wr_valid}, 32'h0);

        // lb lane 3, zero wait states
        applyStimulus(1'b1, 6'b100000, 5'd3, 1'b1, 1'b0, 32'h0000_0103, 32'h0);
        tick();
        dm_ack   = 1'b1;
        dm_rdata = 32'h8011_2233;
        tick();
        dm_ack = 1'b0;
        applyStimulus(1'b0, 6'h00, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("lb_wr_valid", {31'h0, Wr_valid}, 32'h1);
        checkOutput("lb_wr_dout", Wr_dout, 32'h0000_0080);
        checkOutput("lb_wr_op", {26'h0, Wr_op}, 32'h20);

        // lbu lane 1 keeps only the selected byte
        applyStimulus(1'b1, 6'b100100, 5'd4, 1'b1, 1'b0, 32'h0000_0101, 32'h0);
        tick();
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        applyStimulus(1'b0, 6'h00, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("lbu_wr_dout", Wr_dout, 32'h0000_0022);

        // sb lane 2
        applyStimulus(1'b1, 6'b101000, 5'd9, 1'b1, 1'b1, 32'h0000_0206, 32'h0000_00A5);
        tick();
        checkOutput("sb_dm_be", {28'h0, dm_be}, 32'h4);
        checkOutput("sb_dm_wdata", dm_wdata, 32'hA5A5_A5A5);
        checkOutput("sb_dm_we", {31'h0, dm_we}, 32'h1);
        checkOutput("sb_dm_addr", {2'b00, dm_addr}, 32'h81);
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        applyStimulus(1'b0, 6'h00, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("sb_wr_valid", {31'h0, Wr_valid}, 32'h1);
        checkOutput("sb_wr_regwr", {31'h0, Wr_RegWr}, 32'h0);

        // sw full word
        applyStimulus(1'b1, 6'b101011, 5'd2, 1'b0, 1'b1, 32'h0000_0300, 32'h1234_5678);
        tick();
        checkOutput("sw_dm_be", {28'h0, dm_be}, 32'hF);
        checkOutput("sw_dm_wdata", dm_wdata, 32'h1234_5678);
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        applyStimulus(1'b0, 6'h00, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);

        // stray ack while idle must do nothing
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        checkOutput("idle_ack_valid", {31'h0, Wr_valid}, 32'h0);
        checkOutput("idle_ack_req", {31'h0, dm_req}, 32'h0);

        // reset in the middle of a pending lw
        applyStimulus(1'b1, 6'b100011, 5'd8, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
        tick();
        checkOutput("rstmid_req_before", {31'h0, dm_req}, 32'h1);
        rst = 1'b1;
        applyStimulus(1'b0, 6'h00, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rstmid_req", {31'h0, dm_req}, 32'h0);
        checkOutput("rstmid_stall", {31'h0, mem_stall}, 32'h0);
        checkOutput("rstmid_wr_valid", {31'h0, Wr_valid}, 32'h0);
        tick();
        checkOutput("rstmid_idle", {31'h0, Wr_valid | dm_req}, 32'h0);

`ifdef MEM_TIMEOUT_EN
        // sw never acknowledged: retired after 16 WAIT cycles with mem_err set
        applyStimulus(1'b1, 6'b101011, 5'd6, 1'b1, 1'b1, 32'h0000_0500, 32'hCAFE_F00D);
        tick();
        waits = 0;
        while (dm_req && waits < 40) begin
            waits++;
            tick();
        end
        applyStimulus(1'b0, 6'h00, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("tmo_wait_cycles", waits, 32'd16);
        checkOutput("tmo_wr_valid", {31'h0, Wr_valid}, 32'h1);
        checkOutput("tmo_wr_regwr", {31'h0, Wr_RegWr}, 32'h0);
        checkOutput("tmo_wr_dout", Wr_dout, 32'h0);
        checkOutput("tmo_mem_err", {31'h0, mem_err}, 32'h1);
        applyStimulus(1'b1, 6'b000000, 5'd1, 1'b1, 1'b0, 32'h0000_0077, 32'h0);
        tick();
        applyStimulus(1'b0, 6'h00, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("tmo_err_sticky", {31'h0, mem_err}, 32'h1);
        checkOutput("tmo_next_alu", Wr_alure, 32'h0000_0077);
`else
        // without the timeout feature an unacknowledged access waits forever
        applyStimulus(1'b1, 6'b101011, 5'd6, 1'b1, 1'b1, 32'h0000_0500, 32'hCAFE_F00D);
        tick();
        waits = 0;
        while (dm_req && waits < 24) begin
            waits++;
            tick();
        end
        checkOutput("notmo_still_waiting", waits, 32'd24);
        checkOutput("notmo_stall", {31'h0, mem_stall}, 32'h1);
        checkOutput("notmo_mem_err", {31'h0, mem_err}, 32'h0);
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        applyStimulus(1'b0, 6'h00, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("notmo_retire", {31'h0, Wr_valid}, 32'h1);
        checkOutput("notmo_regwr", {31'h0, Wr_RegWr}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports: clk  in  1  pipeline clock (rising edge); rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these upstream (Ex/Mem register) inputs: Mem_valid in 1 instruction present; Mem_op in 6 opcode; Mem_Reg in 5 destination register; Mem_RegWr in 1; Mem_MemtoReg in 1; Mem_MemWr in 1; Mem_alure in 32 ALU result / effective address; Mem_busB in 32 store data; Mem_PC in [31:2].
REQ-003 The block SHALL have these data-memory ports: dm_req out 1; dm_we out 1; dm_addr out [31:2]; dm_be out 4 byte enables; dm_wdata out 32; dm_ack in 1; dm_rdata in 32.
REQ-004 The block SHALL have these downstream outputs, all registered: Wr_valid out 1; Wr_op out 6; Wr_Reg out 5; Wr_RegWr out 1; Wr_MemtoReg out 1; Wr_alure out 32; Wr_dout out 32; Wr_PC out [31:2].
REQ-005 The block SHALL have the following further outputs: mem_stall out 1 (hold upstream); mem_err out 1 (sticky timeout flag).

Function
REQ-006 Memory operations SHALL be: loads lw 100011, lb 100000, lbu 100100; stores sw 101011, sb 101000. All other opcodes are non-memory.
REQ-007 The FSM SHALL have two states: IDLE and WAIT. IDLE -> WAIT on Mem_valid with a memory opcode. WAIT -> IDLE on the edge where dm_ack=1.
REQ-008 Non-memory instructions with Mem_valid=1 in IDLE SHALL be copied to the Wr_* outputs at the next edge with Wr_valid=1, giving 1-cycle latency; Wr_dout SHALL be 0.
REQ-009 In WAIT, dm_req SHALL be 1, and dm_we, dm_addr, dm_be and dm_wdata SHALL hold constant until ack; dm_addr = Mem_alure[31:2].
REQ-010 mem_stall SHALL be combinational: 1 when (IDLE & Mem_valid & memory op) or (WAIT & !dm_ack); upstream holds the Mem_* inputs stable while mem_stall=1.
REQ-011 At the edge where dm_ack=1 in WAIT, the block SHALL present the instruction on Wr_* with Wr_valid=1. Minimum memory-op latency is 2 edges (ack in the first WAIT cycle).
REQ-012 While an op is pending, Wr_valid SHALL be 0, with Wr_RegWr forced to 0, so that bubbles are inserted.
REQ-013 For sw, dm_be SHALL be 1111, with dm_wdata = Mem_busB.
REQ-014 For sb, dm_be SHALL be one-hot at lane Mem_alure[1:0] (00 -> 0001, 11 -> 1000), and dm_wdata SHALL be Mem_busB[7:0] replicated 4 times.
REQ-015 For lw, dm_be SHALL be 1111, and Wr_dout SHALL be dm_rdata; address bits [1:0] are ignored, with no alignment trap.
REQ-016 For lb/lbu, dm_be SHALL be 1111, and Wr_dout SHALL be dm_rdata shifted right by 8*Mem_alure[1:0], with the upper bits zero; the selected byte lands in Wr_dout[7:0] for Wr-stage extension.
REQ-017 For stores, Wr_RegWr SHALL be 0 regardless of Mem_RegWr.
REQ-018 dm_ack while in IDLE SHALL be ignored.

Reset
REQ-019 When rst=1 at an edge, the FSM SHALL go to IDLE regardless of state, including mid-WAIT; an in-flight access is abandoned without being retired.
REQ-020 After reset, all Wr_* outputs, dm_req, dm_we, dm_be and mem_err SHALL be 0.

Configuration
REQ-021 With MEM_TIMEOUT_EN defined, a 4-bit counter SHALL clear on WAIT entry and increment each WAIT cycle without ack. At count 15 with no ack, the block SHALL return to IDLE, retire the instruction with Wr_valid=1, Wr_RegWr=0 and Wr_dout=0, and set mem_err; mem_err is cleared only by rst.
REQ-022 Without MEM_TIMEOUT_EN, WAIT SHALL persist indefinitely, there SHALL be no counter, and mem_err SHALL be tied to 0.

Verification
REQ-023 Reset mid-WAIT: lw issued, rst pulsed before ack -> next cycle dm_req=0, mem_stall=0, Wr_valid=0, FSM in IDLE.
REQ-024 ALU op: Mem_op=000000, Mem_alure=0x1234, Mem_Reg=5 -> 1 edge later Wr_valid=1, Wr_alure=0x1234, Wr_Reg=5, Wr_dout=0, mem_stall never 1.
REQ-025 lw with 3 wait states: addr 0x100, dm_rdata=0xDEADBEEF on ack -> dm_addr=0x40, mem_stall high 4 cycles, Wr_dout=0xDEADBEEF, Wr_valid=1 exactly one cycle.
REQ-026 lb lane 3: addr 0x103, dm_rdata=0x80112233, 0-wait ack -> Wr_dout=0x00000080, Wr_op=100000.
REQ-027 sb lane 2: addr 0x206, busB=0x000000A5 -> dm_be=0100, dm_wdata=0xA5A5A5A5, dm_we=1, Wr_RegWr=0.
REQ-028 MEM_TIMEOUT_EN: sw with dm_ack held 0 -> retired after 16 WAIT cycles, mem_err=1 and remaining 1 after later ops.
